stats_cmd_arbiter: RTL and testbench
====================================

STATS_CMD_ARBITER -- requirements
Module: stats_cmd_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 27000000, clock cycles per stat-decay tick.
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 clk  in  1  system clock; all state on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 uart_data  in  8  received UART byte.
REQ-006 uart_valid  in  1  uart_data valid; transfer occurs when uart_valid && uart_ready.
REQ-007 uart_ready  out  1  UART holding register empty.
REQ-008 btn_pulse  in  3  debounced single-cycle pulses: [0] feed, [1] play, [2] clean.
REQ-009 cmd_valid  out  1  command offered to stats datapath.
REQ-010 cmd_code  out  3  command: 1 FEED, 2 PLAY, 3 CLEAN, 4 SLEEP.
REQ-011 cmd_ready  in  1  stats datapath accepts; transfer when cmd_valid && cmd_ready.
REQ-012 decay_tick  out  1  one-cycle pulse every TICK_DIV cycles.
REQ-013 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 drop_count  out  8  dropped button requests, saturating.

Function
REQ-015 UART decode on acceptance: 0x65 'e'->FEED, 0x70 'p'->PLAY, 0x63 'c'->CLEAN, 0x7A 'z'->SLEEP; any other byte discarded without entering the holding register or counting as a drop.
REQ-016 A decoded UART command occupies a one-entry holding register; uart_ready = holding register empty.
REQ-017 Each btn_pulse bit sets a sticky pending bit; a pulse on an already-set pending bit increments drop_count (saturates at 255, no wrap).
REQ-018 At most one enqueue per cycle, only when FIFO not full.
REQ-019 Source arbitration is round-robin between UART holding and button pending: when both request, grant the source not granted last; the pointer updates only on a grant.
REQ-020 Within button pending, the lowest set index wins; the granted pending bit clears in the same cycle it enqueues (a same-cycle new pulse on that bit sets it again, no drop).
REQ-021 FIFO full: no enqueue; holding register and pending bits retain their state; uart_ready stays low while holding is occupied.
REQ-022 Output FSM states: IDLE, PRESENT, GAP.
REQ-023 IDLE: cmd_valid=0; go to PRESENT on the cycle after FIFO becomes non-empty (head registered onto cmd_code).
REQ-024 PRESENT: cmd_valid=1, cmd_code stable until handshake; on cmd_valid && cmd_ready, dequeue and go to GAP.
REQ-025 GAP: cmd_valid=0 for exactly one cycle, then PRESENT if FIFO non-empty, else IDLE.
REQ-026 Simultaneous enqueue and dequeue when FIFO full or empty is legal; fifo_level is unchanged by the pair.
REQ-027 Minimum enqueue-to-cmd_valid latency is 2 cycles from an empty FIFO; sustained throughput is one command per 2 cycles.
REQ-028 Tick counter counts 0..TICK_DIV-1, wraps to 0; decay_tick=1 exactly in the cycle the count equals TICK_DIV-1; it is independent of the FSM and cmd_ready.

Reset
REQ-029 reset_n low asynchronously forces: FSM=IDLE, cmd_valid=0, cmd_code=0, FIFO empty, fifo_level=0, holding empty, uart_ready=1, pending=0, RR pointer=UART, tick counter=0, decay_tick=0, drop_count=0.
REQ-030 Reset mid-handshake discards the offered command and all queued commands; nothing is replayed after release.
REQ-031 First decay_tick occurs TICK_DIV cycles after reset_n deasserts.

Verification
REQ-032 uart 0x65 accepted, cmd_ready=1 -> cmd_valid with cmd_code=1 two cycles after acceptance, held one cycle, then GAP.
REQ-033 Same cycle uart 0x70 and btn_pulse=3'b101 with empty FIFO -> enqueue order PLAY, FEED, CLEAN (RR alternation, lowest btn first); drop_count=0.
REQ-034 cmd_ready=0, 5 accepted commands with DEPTH=4 -> fifo_level=4, uart_ready=0 until cmd_ready=1, then all 5 commands delivered in order.
REQ-035 btn_pulse[1] three times while FIFO full -> drop_count=2, exactly one PLAY delivered after drain.
REQ-036 TICK_DIV=5 -> decay_tick high at cycles 5, 10, 15 after reset release; reset_n low at cycle 7 -> counter and queued commands cleared, next tick 5 cycles after release.
REQ-037 uart 0x41 -> uart_ready remains 1, no enqueue, drop_count unchanged.

Source files
------------

// File: rtl/stats_cmd_arbiter.sv
// stats_cmd_arbiter: merges decoded UART commands and button requests into a
// small command FIFO, presents them to the stats datapath with a one-cycle gap
// between commands, and generates the periodic stat-decay tick.
module stats_cmd_arbiter #(
    parameter int unsigned TICK_DIV = 27000000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             uart_data,
    input  logic                   uart_valid,
    output logic                   uart_ready,
    input  logic [2:0]             btn_pulse,
    output logic                   cmd_valid,
    output logic [2:0]             cmd_code,
    input  logic                   cmd_ready,
    output logic                   decay_tick,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_FEED  = 3'd1;
    localparam logic [2:0] CMD_PLAY  = 3'd2;
    localparam logic [2:0] CMD_CLEAN = 3'd3;
    localparam logic [2:0] CMD_SLEEP = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    // UART side
    logic          hold_valid_q, hold_valid_d;
    logic [2:0]    hold_code_q, hold_code_d;
    logic          uart_acc;
    logic          dec_valid;
    logic [2:0]    dec_code;
    logic          uart_req;
    logic [2:0]    uart_req_code;

    // Button side
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    btn_sel;
    logic [2:0]    btn_code;
    logic [2:0]    pend_clr;
    logic          btn_req;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;
    logic [7:0]    drop_count_d;

    // Arbitration
    logic          rr_uart_q;
    logic          enq_ok;
    logic          grant_uart;
    logic          grant_btn;
    logic          enq;
    logic [2:0]    enq_code;

    // FIFO
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          deq;

    // Output FSM
    state_t        state_q, state_d;
    logic          cmd_valid_d;
    logic [2:0]    cmd_code_d;

    // Decay tick
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;

    // Decode an accepted UART byte into a command code
    always_comb begin
        dec_valid = 1'b1;
        dec_code  = CMD_NONE;
        unique case (uart_data)
            8'h65:   dec_code = CMD_FEED;
            8'h70:   dec_code = CMD_PLAY;
            8'h63:   dec_code = CMD_CLEAN;
            8'h7A:   dec_code = CMD_SLEEP;
            default: dec_valid = 1'b0;
        endcase
    end

    assign uart_acc      = uart_valid && uart_ready;
    assign uart_req      = hold_valid_q || (uart_acc && dec_valid);
    assign uart_req_code = hold_valid_q ? hold_code_q : dec_code;

    // Lowest pending button wins within the button source
    always_comb begin
        btn_sel  = 3'b000;
        btn_code = CMD_NONE;
        if (pend_q[0]) begin
            btn_sel  = 3'b001;
            btn_code = CMD_FEED;
        end else if (pend_q[1]) begin
            btn_sel  = 3'b010;
            btn_code = CMD_PLAY;
        end else if (pend_q[2]) begin
            btn_sel  = 3'b100;
            btn_code = CMD_CLEAN;
        end
    end

    assign btn_req = |pend_q;

    // A slot frees up in the same cycle the head is handed off
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LW'(DEPTH));
    assign deq        = (state_q == S_PRESENT) && cmd_ready;
    assign enq_ok     = !fifo_full || deq;

    // Round-robin source grant; rr_uart_q set means UART has priority next
    assign grant_uart = enq_ok && uart_req && (!btn_req || rr_uart_q);
    assign grant_btn  = enq_ok && btn_req && !grant_uart;
    assign enq        = grant_uart || grant_btn;
    assign enq_code   = grant_uart ? uart_req_code : btn_code;
    assign pend_clr   = grant_btn ? btn_sel : 3'b000;

    // Holding register: bypassed when the fresh UART command is granted at once
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_code_d  = hold_code_q;
        if (grant_uart) begin
            hold_valid_d = 1'b0;
        end else if (uart_acc && dec_valid) begin
            hold_valid_d = 1'b1;
            hold_code_d  = dec_code;
        end
    end

    // Sticky pending bits and saturating drop counter
    always_comb begin
        pend_d   = (pend_q & ~pend_clr) | btn_pulse;
        drop_inc = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (btn_pulse[i] && pend_q[i] && !pend_clr[i]) begin
                drop_inc = drop_inc + 2'd1;
            end
        end
        drop_sum     = {1'b0, drop_count} + {7'd0, drop_inc};
        drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Source-side state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_code_q  <= CMD_NONE;
            uart_ready   <= 1'b1;
            pend_q       <= 3'b000;
            drop_count   <= 8'd0;
            rr_uart_q    <= 1'b1;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_code_q  <= hold_code_d;
            uart_ready   <= !hold_valid_d;
            pend_q       <= pend_d;
            drop_count   <= drop_count_d;
            if (grant_uart) begin
                rr_uart_q <= 1'b0;
            end else if (grant_btn) begin
                rr_uart_q <= 1'b1;
            end
        end
    end

    // FIFO occupancy after this cycle's enqueue/dequeue pair
    always_comb begin
        unique case ({enq, deq})
            2'b10:   level_d = fifo_level + LW'(1);
            2'b01:   level_d = fifo_level - LW'(1);
            default: level_d = fifo_level;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= enq_code;
        end
    end

    // FIFO pointers and level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fifo_level <= level_d;
        end
    end

    // Output FSM next-state and registered command outputs
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = S_PRESENT;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = mem[rd_ptr_q];
                end
            end
            S_PRESENT: begin
                cmd_valid_d = 1'b1;
                if (cmd_ready) begin
                    state_d     = S_GAP;
                    cmd_valid_d = 1'b0;
                end
            end
            S_GAP: begin
                if (!fifo_empty) begin
                    state_d     = S_PRESENT;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = mem[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NONE;
        end else begin
            state_q   <= state_d;
            cmd_valid <= cmd_valid_d;
            cmd_code  <= cmd_code_d;
        end
    end

    // Free-running decay tick counter
    always_comb begin
        tick_cnt_d = (tick_cnt_q == CW'(TICK_DIV - 1)) ? '0 : tick_cnt_q + CW'(1);
    end

    // Tick pulse is registered alongside the count it marks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            decay_tick <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            decay_tick <= (tick_cnt_d == CW'(TICK_DIV - 1));
        end
    end

endmodule

// File: tb/tb_stats_cmd_arbiter.sv
// tb_stats_cmd_arbiter: directed vector table plus hand-written sequences for
// the arbiter, FIFO back-pressure, drop counting and decay tick.
module tb_stats_cmd_arbiter;

    localparam int unsigned TICK_DIV = 5;
    localparam int unsigned DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;
    logic [2:0] btn_pulse;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic       decay_tick;
    logic [2:0] fifo_level;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       uv;
        logic [2:0] btn;
        logic       cr;
        logic       ur;
        logic       cv;
        logic [2:0] code;
        int         lvl;
        int         drop;
    } vec_t;

    vec_t vecs[$];

    stats_cmd_arbiter #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .btn_pulse  (btn_pulse),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .decay_tick (decay_tick),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic void add(input logic [7:0] d, input logic uv, input logic [2:0] b,
                                input logic cr, input logic ur, input logic cv,
                                input logic [2:0] c, input int l, input int dr);
        vec_t v;
        v.data = d; v.uv = uv; v.btn = b; v.cr = cr;
        v.ur = ur; v.cv = cv; v.code = c; v.lvl = l; v.drop = dr;
        vecs.push_back(v);
    endfunction

    // Hand off everything queued with cmd_ready high and compare against exp_q
    task automatic drain(input string name, input int budget);
        int got[$];
        cmd_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (cmd_valid) got.push_back(int'(cmd_code));
            step();
        end
        cmd_ready = 1'b0;
        chk({name, " count"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s cmd%0d", name, k), (k < got.size()) ? got[k] : -1, exp_q[k]);
        end
    endtask

    initial begin
        int seen;

        reset_n    = 1'b0;
        uart_data  = 8'h00;
        uart_valid = 1'b0;
        btn_pulse  = 3'b000;
        cmd_ready  = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst uart_ready", int'(uart_ready), 1);
        chk("rst cmd_valid", int'(cmd_valid), 0);
        chk("rst cmd_code", int'(cmd_code), 0);
        chk("rst fifo_level", int'(fifo_level), 0);
        chk("rst drop_count", int'(drop_count), 0);
        chk("rst decay_tick", int'(decay_tick), 0);

        // Decay tick period, then reset in cycle 7 restarts it
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("tick a%0d", k), int'(decay_tick), (k % 5 == 4) ? 1 : 0);
        end
        reset_n = 1'b0;
        #1;
        chk("tick in reset", int'(decay_tick), 0);
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("tick b%0d", k), int'(decay_tick), (k % 5 == 4) ? 1 : 0);
        end

        // data, uv, btn, cr | uart_ready, cmd_valid, cmd_code, level, drops
        add(8'h41, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 3'd0, 0, 0);
        add(8'h65, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 3'd0, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd1, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 0, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 0, 0);
        add(8'h70, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 3'd1, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 3'd2, 2, 0);
        add(8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 3'd2, 3, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd2, 2, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd1, 2, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd3, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd3, 0, 0);
        add(8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'd3, 0, 0);
        add(8'h7A, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 3'd3, 1, 0);
        add(8'h65, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 3'd4, 2, 0);
        add(8'h70, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 3'd4, 3, 0);
        add(8'h63, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 3'd4, 4, 0);
        add(8'h65, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 3'd4, 4, 0);
        add(8'h70, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 3'd4, 4, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd4, 4, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd1, 4, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 3, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd2, 3, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd2, 2, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd3, 2, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd3, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 3'd1, 1, 0);
        add(8'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 0, 0);
        add(8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'd1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            uart_data  = vecs[i].data;
            uart_valid = vecs[i].uv;
            btn_pulse  = vecs[i].btn;
            cmd_ready  = vecs[i].cr;
            step();
            chk($sformatf("row%0d uart_ready", i), int'(uart_ready), int'(vecs[i].ur));
            chk($sformatf("row%0d cmd_valid", i), int'(cmd_valid), int'(vecs[i].cv));
            chk($sformatf("row%0d cmd_code", i), int'(cmd_code), int'(vecs[i].code));
            chk($sformatf("row%0d fifo_level", i), int'(fifo_level), vecs[i].lvl);
            chk($sformatf("row%0d drop_count", i), int'(drop_count), vecs[i].drop);
        end
        uart_valid = 1'b0;
        btn_pulse  = 3'b000;
        cmd_ready  = 1'b0;

        // Drops while full, then both sources contend during drain
        uart_data  = 8'h65;
        uart_valid = 1'b1;
        repeat (4) step();
        uart_valid = 1'b0;
        chk("seqA full level", int'(fifo_level), 4);
        btn_pulse = 3'b010;
        step();
        chk("seqA drop after 1st", int'(drop_count), 0);
        step();
        chk("seqA drop after 2nd", int'(drop_count), 1);
        step();
        chk("seqA drop after 3rd", int'(drop_count), 2);
        btn_pulse  = 3'b000;
        uart_data  = 8'h63;
        uart_valid = 1'b1;
        step();
        uart_valid = 1'b0;
        step();
        chk("seqA uart_ready held", int'(uart_ready), 0);
        chk("seqA level", int'(fifo_level), 4);
        chk("seqA drop", int'(drop_count), 2);
        exp_q = '{1, 1, 1, 1, 2, 3};
        drain("seqA", 20);
        chk("seqA level drained", int'(fifo_level), 0);
        chk("seqA uart_ready free", int'(uart_ready), 1);

        // Granted pending bit re-armed by a same-cycle pulse is not a drop
        btn_pulse = 3'b001;
        step();
        step();
        chk("seqB drop", int'(drop_count), 2);
        chk("seqB level1", int'(fifo_level), 1);
        btn_pulse = 3'b000;
        step();
        chk("seqB level2", int'(fifo_level), 2);
        exp_q = '{1, 1};
        drain("seqB", 10);

        // Saturating drop counter with three drops per cycle
        uart_data  = 8'h7A;
        uart_valid = 1'b1;
        repeat (4) step();
        uart_valid = 1'b0;
        btn_pulse  = 3'b111;
        step();
        chk("sat arm", int'(drop_count), 2);
        step();
        chk("sat triple", int'(drop_count), 5);
        repeat (83) step();
        chk("sat 254", int'(drop_count), 254);
        step();
        chk("sat clamp", int'(drop_count), 255);
        repeat (4) step();
        chk("sat hold", int'(drop_count), 255);
        btn_pulse = 3'b000;
        chk("sat cmd_code", int'(cmd_code), 4);

        // Reset mid-handshake discards everything
        cmd_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk("rst2 cmd_valid", int'(cmd_valid), 0);
        chk("rst2 cmd_code", int'(cmd_code), 0);
        chk("rst2 fifo_level", int'(fifo_level), 0);
        chk("rst2 drop_count", int'(drop_count), 0);
        chk("rst2 uart_ready", int'(uart_ready), 1);
        step();
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (cmd_valid) seen++;
        end
        chk("rst2 no replay", seen, 0);
        chk("rst2 level after", int'(fifo_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
